// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receiver: FSM state encoding, frame width, parity rule.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int FRAME_BITS = 8;

  // PS/2 uses odd parity: data ones plus the parity bit must be odd.
  function automatic logic odd_parity_ok(input logic [FRAME_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word fall-through FIFO; dout is 0 when empty, writes visible one clk after push.
// Push while full is dropped unless a pop occurs in the same cycle; pop while empty is ignored.
module ps2_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // A pop frees the slot the simultaneous push needs, so full does not block it.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 frame receiver feeding a scan-code FIFO; good frame visible 1 clk after the detected stop edge.
// No backpressure on the PS/2 side: frames arriving at a full FIFO are dropped and flagged by overflow.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int PARITY_EN   = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  input  logic                            rd_en,
  output logic [7:0]                      data_out,
  output logic                            valid,
  output logic                            full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overflow
);

  localparam int TW = $clog2(TIMEOUT_CYC+1);
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC-1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS-1);

  logic ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_prev_q;
  logic ps2_dat_meta_q, ps2_dat_sync_q;
  logic fall;

  ps2_state_e            state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  ovf_q, ovf_d;
  logic                  frame_good;

  logic                  fifo_full, fifo_empty;

  // Synchronisers rest at the idle line level so leaving reset never fakes a falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps2_clk_meta_q <= 1'b1;
      ps2_clk_sync_q <= 1'b1;
      ps2_clk_prev_q <= 1'b1;
      ps2_dat_meta_q <= 1'b1;
      ps2_dat_sync_q <= 1'b1;
    end else begin
      ps2_clk_meta_q <= ps2_clk;
      ps2_clk_sync_q <= ps2_clk_meta_q;
      ps2_clk_prev_q <= ps2_clk_sync_q;
      ps2_dat_meta_q <= ps2_data;
      ps2_dat_sync_q <= ps2_dat_meta_q;
    end
  end

  assign fall = ps2_clk_prev_q & ~ps2_clk_sync_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tmo_d      = tmo_q;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    frame_good = 1'b0;

    if (state_q == IDLE || fall) tmo_d = '0;
    else                         tmo_d = tmo_q + TW'(1);

    case (state_q)
      IDLE: begin
        if (fall && !ps2_dat_sync_q) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {ps2_dat_sync_q, shift_q[FRAME_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BIT_LAST) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = ps2_dat_sync_q;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          // A bad stop bit outranks a parity mismatch.
          if (!ps2_dat_sync_q)
            ferr_d = 1'b1;
          else if ((PARITY_EN != 0) && !odd_parity_ok(shift_q, par_q))
            perr_d = 1'b1;
          else
            frame_good = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && !fall && tmo_q == TMO_LAST) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
      tmo_d   = '0;
    end
  end

  // A full FIFO still takes the frame when the reader pops in the same cycle.
  assign ovf_d = frame_good & fifo_full & ~rd_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovf_q     <= ovf_d;
    end
  end

  ps2_sync_fifo #(
    .WIDTH (FRAME_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (frame_good),
    .din   (shift_q),
    .pop   (rd_en),
    .dout  (data_out),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign valid      = ~fifo_empty;
  assign full       = fifo_full;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench: two receivers (parity enforced / ignored) share one PS/2 line and are scored against queue models.
module tb_ps2_rx_fifo;

  localparam int DEPTH = 4;
  localparam int TMO   = 200;
  localparam int CW    = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic rd_en = 1'b0;

  logic [7:0]    dout_p, dout_n;
  logic          valid_p, valid_n, full_p, full_n;
  logic [CW-1:0] count_p, count_n;
  logic          perr_p, perr_n, ferr_p, ferr_n, ovf_p, ovf_n;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .PARITY_EN(1)) dut_p (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .data_out(dout_p), .valid(valid_p), .full(full_p), .count(count_p),
    .parity_err(perr_p), .frame_err(ferr_p), .overflow(ovf_p));

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .PARITY_EN(0)) dut_n (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .data_out(dout_n), .valid(valid_n), .full(full_n), .count(count_n),
    .parity_err(perr_n), .frame_err(ferr_n), .overflow(ovf_n));

  int n_checks = 0;
  int n_fail = 0;

  // Pulse cycles observed, index 0 = parity enforced, 1 = parity ignored.
  int perr_seen [2];
  int ferr_seen [2];
  int ovf_seen  [2];
  int perr_exp  [2];
  int ferr_exp  [2];
  int ovf_exp   [2];
  logic [7:0] mq [2][$];

  initial begin
    for (int i = 0; i < 2; i++) begin
      perr_seen[i] = 0; ferr_seen[i] = 0; ovf_seen[i] = 0;
      perr_exp[i]  = 0; ferr_exp[i]  = 0; ovf_exp[i]  = 0;
    end
  end

  always @(negedge clk) begin
    if (perr_p) perr_seen[0]++;
    if (perr_n) perr_seen[1]++;
    if (ferr_p) ferr_seen[0]++;
    if (ferr_n) ferr_seen[1]++;
    if (ovf_p)  ovf_seen[0]++;
    if (ovf_n)  ovf_seen[1]++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 2; i++) begin
      logic [31:0] exp_d;
      exp_d = (mq[i].size() > 0) ? {24'd0, mq[i][0]} : 32'd0;
      check($sformatf("%s data_out[%0d]", tag, i), (i == 0) ? dout_p : dout_n, exp_d);
      check($sformatf("%s valid[%0d]", tag, i), (i == 0) ? valid_p : valid_n, mq[i].size() > 0);
      check($sformatf("%s full[%0d]", tag, i), (i == 0) ? full_p : full_n, mq[i].size() == DEPTH);
      check($sformatf("%s count[%0d]", tag, i), (i == 0) ? count_p : count_n, mq[i].size());
      check($sformatf("%s parity_err[%0d]", tag, i), perr_seen[i], perr_exp[i]);
      check($sformatf("%s frame_err[%0d]", tag, i), ferr_seen[i], ferr_exp[i]);
      check($sformatf("%s overflow[%0d]", tag, i), ovf_seen[i], ovf_exp[i]);
    end
  endtask

  // Reference: a complete frame, with an optional read landing in the same cycle as the stop edge.
  task automatic model_frame(input logic [7:0] d, input logic p, input logic s, input bit popped);
    for (int i = 0; i < 2; i++) begin
      int ones;
      ones = $countones(d) + int'(p);
      if (popped && mq[i].size() > 0) void'(mq[i].pop_front());
      if (!s)                             ferr_exp[i]++;
      else if (i == 0 && (ones % 2) == 0) perr_exp[i]++;
      else if (mq[i].size() < DEPTH)      mq[i].push_back(d);
      else                                ovf_exp[i]++;
    end
  endtask

  // Bits change mid-high; ps2_clk low 10 clk, high 10 clk. Called and returns on a negedge.
  task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop,
                            input int nbits, input bit pop_at_stop, input bit lat_chk);
    logic [10:0] bits;
    logic        par;
    par  = (~^d) ^ flip;
    bits = {stop, par, d, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      ps2_data = bits[b];
      repeat (5) @(negedge clk);
      ps2_clk = 1'b0;
      if (b == 10 && pop_at_stop) begin
        repeat (2) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (7) @(negedge clk);
      end else if (b == 10 && lat_chk) begin
        repeat (2) @(negedge clk);
        check("latency before push", valid_p, 1'b0);
        @(negedge clk);
        check("latency at push", valid_p, 1'b1);
        repeat (7) @(negedge clk);
      end else begin
        repeat (10) @(negedge clk);
      end
      ps2_clk = 1'b1;
      repeat (5) @(negedge clk);
    end
    ps2_data = 1'b1;
    if (nbits == 11) model_frame(d, par, stop, pop_at_stop);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_read();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    for (int i = 0; i < 2; i++)
      if (mq[i].size() > 0) void'(mq[i].pop_front());
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] seq [5];
    seq[0] = 8'hF0; seq[1] = 8'hE0; seq[2] = 8'h1C; seq[3] = 8'h5A; seq[4] = 8'h29;

    repeat (3) @(negedge clk);
    check_state("reset");
    reset = 1'b1;
    repeat (3) @(negedge clk);

    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b1);
    check_state("good 1C");
    do_read();
    check_state("read 1C");

    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0, 1'b0);
    check_state("bad parity 1C");
    do_read();
    check_state("drain parity");

    send_frame(8'h3A, 1'b0, 1'b0, 11, 1'b0, 1'b0);
    check_state("bad stop");

    for (int k = 0; k < 5; k++) begin
      send_frame(seq[k], 1'b0, 1'b1, 11, 1'b0, 1'b0);
      check_state($sformatf("fill %0d", k));
    end
    for (int k = 0; k < 4; k++) begin
      check_state($sformatf("order %0d", k));
      do_read();
    end
    check_state("drained");

    for (int k = 0; k < 4; k++) send_frame(seq[k], 1'b0, 1'b1, 11, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b1, 11, 1'b1, 1'b0);
    check_state("full push+pop");
    for (int k = 0; k < 4; k++) begin
      check_state($sformatf("pp order %0d", k));
      do_read();
    end

    send_frame(8'h55, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    repeat (TMO + 20) @(negedge clk);
    for (int i = 0; i < 2; i++) ferr_exp[i]++;
    check_state("timeout");
    send_frame(8'h76, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    check_state("after timeout 76");
    do_read();

    send_frame(8'hA1, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    send_frame(8'hB2, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    check_state("pre-reset");
    send_frame(8'hC3, 1'b0, 1'b1, 4, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check("reset count_p", count_p, 0);
    check("reset valid_p", valid_p, 1'b0);
    check("reset data_out_p", dout_p, 8'h00);
    check("reset count_n", count_n, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) mq[i].delete();
    repeat (3) @(negedge clk);
    check_state("post-reset idle");
    send_frame(8'h45, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    check_state("post-reset 45");
    do_read();

    for (int r = 0; r < 40; r++) begin
      logic [7:0] d;
      d = 8'($urandom);
      send_frame(d, $urandom_range(0, 4) == 0, $urandom_range(0, 7) != 0, 11,
                 $urandom_range(0, 3) == 0, 1'b0);
      check_state($sformatf("rand %0d", r));
      repeat ($urandom_range(0, 1)) do_read();
    end
    while (mq[0].size() > 0 || mq[1].size() > 0) begin
      check_state("final drain");
      do_read();
    end
    check_state("end");

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
